// File: rtl/pwm_bank_pkg.sv
// Purpose: shared constants, types and helpers for the pwm_bank block.
// Latency: none (package only).
// Backpressure: none (package only).
package pwm_bank_pkg;

    // Largest duty value and the length of one edge-aligned period in ticks.
    function automatic int cnt_max(input int cnt_w);
        return (1 << cnt_w) - 1;
    endfunction

    // Width of a channel index; never narrower than one bit.
    function automatic int ch_idx_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    // Output-mode encoding for a single channel.
    typedef enum logic [1:0] {
        OUT_OFF         = 2'd0,
        OUT_STATIC_HIGH = 2'd1,
        OUT_PWM         = 2'd2
    } out_mode_e;

    function automatic out_mode_e decode_mode(input logic en_out, input logic en_pwm);
        if (!en_out) begin
            return OUT_OFF;
        end
        return en_pwm ? OUT_PWM : OUT_STATIC_HIGH;
    endfunction

    function automatic logic drive_level(input out_mode_e mode, input logic raw);
        case (mode)
            OUT_PWM:         return raw;
            OUT_STATIC_HIGH: return 1'b1;
            default:         return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/pwm_bank_if.sv
// Purpose: duty-register write port from the SPI register file into pwm_bank.
// Latency: write lands in the pending register on the clock edge it is presented.
// Backpressure: none; every strobe is accepted, out-of-range indices are dropped.
//   master: duty_wr_en, duty_wr_ch, duty_wr_data driven by the register file
//   slave : same signals consumed by pwm_bank
interface pwm_bank_if
    import pwm_bank_pkg::*;
#(
    parameter int NUM_CH = 16,
    parameter int CNT_W  = 8
) ();
    localparam int CH_W = ch_idx_w(NUM_CH);

    logic             duty_wr_en;
    logic [CH_W-1:0]  duty_wr_ch;
    logic [CNT_W-1:0] duty_wr_data;

    modport master (
        output duty_wr_en,
        output duty_wr_ch,
        output duty_wr_data
    );

    modport slave (
        input duty_wr_en,
        input duty_wr_ch,
        input duty_wr_data
    );
endinterface

// File: rtl/pwm_timebase.sv
// Purpose: prescaler plus period counter shared by all PWM channels.
// Latency: cnt moves one clk after each prescaler tick; boundary is combinational.
// Backpressure: none; free-running.
//   in : clk, rst_n, presc (reload; counter steps every presc+1 clks)
//   out: cnt (period counter), boundary (last tick of the period)
//   PWM_CENTER_ALIGN_EN defined: up/down triangle counter; undefined: sawtooth.
module pwm_timebase
    import pwm_bank_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int PRESC_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PRESC_W-1:0] presc,
    output logic [CNT_W-1:0]   cnt,
    output logic               boundary
);
    localparam int               MAX_I = cnt_max(CNT_W);
    localparam logic [CNT_W-1:0] MAX   = MAX_I[CNT_W-1:0];
    localparam logic [CNT_W-1:0] LAST  = MAX - 1'b1;
    localparam logic [CNT_W-1:0] ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [PRESC_W-1:0] pcnt;
    logic               tick;

    // >= rather than == so that lowering presc below the running count
    // wraps on the very next cycle instead of running all the way round.
    assign tick = (pcnt >= presc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
        end else if (tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

`ifdef PWM_CENTER_ALIGN_EN
    logic up;

    // Reload at the valley so both halves of the triangle use one duty.
    assign boundary = tick && !up && (cnt == ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            up  <= 1'b1;
        end else if (tick) begin
            if (up) begin
                if (cnt == MAX) begin
                    cnt <= MAX - 1'b1;
                    up  <= 1'b0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= cnt - 1'b1;
                if (cnt == ONE) begin
                    up <= 1'b1;
                end
            end
        end
    end
`else
    // Wrap at MAX-1 so the period is MAX ticks and duty=MAX is solid high.
    assign boundary = tick && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= (cnt == LAST) ? '0 : cnt + ONE;
        end
    end
`endif

endmodule

// File: rtl/pwm_bank.sv
// Purpose: NUM_CH-channel PWM with shadowed duties reloaded only at period boundaries.
// Latency: out is registered one clk after cnt/active; period_start one clk after boundary.
// Backpressure: none; duty writes always accepted, out-of-range channel writes dropped.
//   in : clk, rst_n, en_out, en_pwm, presc, duty_if (slave: duty_wr_en/ch/data)
//   out: period_start (pulse aligned with cnt==0 and freshly loaded duties), out
//   PWM_CENTER_ALIGN_EN selects a centre-aligned (triangle) time base.
module pwm_bank
    import pwm_bank_pkg::*;
#(
    parameter int NUM_CH  = 16,
    parameter int CNT_W   = 8,
    parameter int PRESC_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_CH-1:0]  en_out,
    input  logic [NUM_CH-1:0]  en_pwm,
    input  logic [PRESC_W-1:0] presc,
    pwm_bank_if.slave          duty_if,
    output logic               period_start,
    output logic [NUM_CH-1:0]  out
);
    localparam int CH_W = ch_idx_w(NUM_CH);

    logic [CNT_W-1:0]  cnt;
    logic              boundary;
    logic [NUM_CH-1:0] out_nxt;

    pwm_timebase #(
        .CNT_W   (CNT_W),
        .PRESC_W (PRESC_W)
    ) u_timebase (
        .clk      (clk),
        .rst_n    (rst_n),
        .presc    (presc),
        .cnt      (cnt),
        .boundary (boundary)
    );

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] pending;
        logic [CNT_W-1:0] active;
        logic             wr_hit;
        logic             raw;

        // Indices with no matching channel simply never hit.
        assign wr_hit = duty_if.duty_wr_en && (duty_if.duty_wr_ch == CH_W'(i));

        // A write on the boundary edge lands in pending while active takes
        // the old pending value, so it shows up one period later.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pending <= '0;
                active  <= '0;
            end else begin
                if (wr_hit) begin
                    pending <= duty_if.duty_wr_data;
                end
                if (boundary) begin
                    active <= pending;
                end
            end
        end

        assign raw        = (cnt < active);
        assign out_nxt[i] = drive_level(decode_mode(en_out[i], en_pwm[i]), raw);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out          <= '0;
            period_start <= 1'b0;
        end else begin
            out          <= out_nxt;
            period_start <= boundary;
        end
    end

endmodule

// File: tb/tb_pwm_bank.sv
// Purpose: directed bench for pwm_bank (12 channels so out-of-range indices exist).
// Latency: samples on the falling edge, half a clock after each update.
// Backpressure: not applicable.
module tb_pwm_bank;
    localparam int NCH = 12;
    localparam int CW  = 8;
    localparam int PW  = 4;
    localparam int CHW = $clog2(NCH);

    logic           clk = 1'b0;
    logic           rst_n;
    logic [NCH-1:0] en_out;
    logic [NCH-1:0] en_pwm;
    logic [PW-1:0]  presc;
    logic           period_start;
    logic [NCH-1:0] out;

    always #5 clk = ~clk;

    pwm_bank_if #(.NUM_CH(NCH), .CNT_W(CW)) duty_if ();

    pwm_bank #(
        .NUM_CH  (NCH),
        .CNT_W   (CW),
        .PRESC_W (PW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en_out       (en_out),
        .en_pwm       (en_pwm),
        .presc        (presc),
        .duty_if      (duty_if.slave),
        .period_start (period_start),
        .out          (out)
    );

    int total = 0;
    int bad   = 0;
    int hi[NCH];
    int cyc;
    int nz;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wr(input int ch, input int data);
        duty_if.duty_wr_en   = 1'b1;
        duty_if.duty_wr_ch   = ch[CHW-1:0];
        duty_if.duty_wr_data = data[CW-1:0];
        @(negedge clk);
        duty_if.duty_wr_en   = 1'b0;
    endtask

    // Advance to the next period_start; reports cycles with any output high.
    task automatic wait_ps(input string tag, output int nonzero);
        int n;
        n       = 0;
        nonzero = 0;
        do begin
            @(negedge clk);
            n++;
            if (out != '0) nonzero++;
        end while (!period_start && n < 3000);
        chk(tag, int'(period_start), 1);
    endtask

    // From a period_start cycle, count samples up to and including the next one.
    // Because out lags cnt by one clk, this window covers exactly one period.
    task automatic measure(input string tag);
        cyc = 0;
        for (int i = 0; i < NCH; i++) hi[i] = 0;
        do begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < NCH; i++) if (out[i]) hi[i]++;
        end while (!period_start && cyc < 5000);
        chk({tag, "_end"}, int'(period_start), 1);
    endtask

    initial begin
        rst_n                = 1'b0;
        en_out               = '0;
        en_pwm               = '0;
        presc                = '0;
        duty_if.duty_wr_en   = 1'b0;
        duty_if.duty_wr_ch   = '0;
        duty_if.duty_wr_data = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_out", int'(out), 0);
        chk("rst_ps", int'(period_start), 0);
        rst_n  = 1'b1;
        en_out = '1;
        en_pwm = '1;
        @(negedge clk);
        chk("post_rst_out", int'(out), 0);

        // First period: duties written but not yet active
        wr(0, 64);
        wr(1, 0);
        wr(2, 10);
        wr(3, 255);
        wr(5, 128);
        wait_ps("first_ps", nz);
        chk("first_period_out_low", nz, 0);

        measure("p1");
        chk("p1_len", cyc, 255);
        chk("p1_ch0", hi[0], 64);
        chk("p1_ch1", hi[1], 0);
        chk("p1_ch2", hi[2], 10);
        chk("p1_ch3", hi[3], 255);
        chk("p1_ch5", hi[5], 128);

        // Write ch2 on the exact boundary cycle (cnt==254, presc=0)
        repeat (254) @(negedge clk);
        duty_if.duty_wr_en   = 1'b1;
        duty_if.duty_wr_ch   = CHW'(2);
        duty_if.duty_wr_data = CW'(200);
        @(negedge clk);
        duty_if.duty_wr_en   = 1'b0;
        chk("bwr_ps_aligned", int'(period_start), 1);
        measure("bwr1");
        chk("bwr1_ch2_old", hi[2], 10);
        measure("bwr2");
        chk("bwr2_ch2_new", hi[2], 200);
        chk("bwr2_ch0", hi[0], 64);

        // Prescaler: counter steps every 4 clks
        presc = PW'(3);
        wait_ps("presc_ps", nz);
        measure("pr1");
        chk("pr1_len", cyc, 1020);
        chk("pr1_ch5", hi[5], 512);
        chk("pr1_ch0", hi[0], 256);
        chk("pr1_ch3", hi[3], 1020);
        measure("pr2");
        chk("pr2_len", cyc, 1020);

        presc = '0;
        wait_ps("presc0_ps", nz);

        // Static-high and output-enable controls act on the next clk
        en_pwm[4] = 1'b0;
        @(negedge clk);
        chk("static_ch4_hi", int'(out[4]), 1);
        en_out[4] = 1'b0;
        @(negedge clk);
        chk("disabled_ch4_lo", int'(out[4]), 0);
        en_pwm[1] = 1'b0;
        @(negedge clk);
        chk("static_ch1_hi", int'(out[1]), 1);
        en_pwm    = '1;
        en_out    = '1;

        // Out-of-range writes must not touch any channel
        wr(12, 99);
        wr(15, 77);
        wait_ps("oor_ps", nz);
        measure("oor");
        chk("oor_len", cyc, 255);
        for (int i = 0; i < NCH; i++) begin
            int e;
            case (i)
                0:       e = 64;
                2:       e = 200;
                3:       e = 255;
                5:       e = 128;
                default: e = 0;
            endcase
            chk($sformatf("oor_ch%0d", i), hi[i], e);
        end

        // Asynchronous reset mid-period with outputs high
        repeat (10) @(negedge clk);
        chk("pre_rst_ch3", int'(out[3]), 1);
        chk("pre_rst_ch0", int'(out[0]), 1);
        #1 rst_n = 1'b0;
        #1 chk("async_rst_out", int'(out), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ps("rst2_ps", nz);
        chk("rst2_first_low", nz, 0);
        measure("rst2");
        chk("rst2_len", cyc, 255);
        chk("rst2_all_low", hi[0] + hi[2] + hi[3] + hi[5], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
